// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard detection with a shadow EX/MEM/WB pipeline
//
// Purpose: tracks the destination of the instructions in EX, MEM and WB and
// raises stall/bubble for a load-use pair, flush for a taken branch, and
// counts stall cycles and flushes with saturating counters.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid                       an instruction occupies ID
//   id_rs, id_rt                   ID source registers
//   id_useRs, id_useRt             ID instruction reads rs / rt
//   id_regWr, id_memRead, id_rd    ID writer flag, load flag, destination
//   branchTaken                    branch in EX resolved taken this cycle
//   stall, bubble, flush           pipeline control, combinational
//   IDEXmemRead, IDEXrd            EX slot
//   EXMEMregWr, EXMEMrd            MEM slot (regWr masked when rd is 0)
//   MEMWBregWr, MEMWBrd            WB slot  (regWr masked when rd is 0)
//   stallCnt, flushCnt             saturating event counters

module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_useRs,
  input  logic             id_useRt,
  input  logic             id_regWr,
  input  logic             id_memRead,
  input  logic [4:0]       id_rd,
  input  logic             branchTaken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             EXMEMregWr,
  output logic [4:0]       EXMEMrd,
  output logic             MEMWBregWr,
  output logic [4:0]       MEMWBrd,
  output logic             IDEXmemRead,
  output logic [4:0]       IDEXrd,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  typedef struct packed {
    logic       reg_wr;
    logic       mem_read;
    logic [4:0] rd;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic  hazard;

  // A load in EX whose result is read by ID cannot be forwarded in time.
  // Register 0 is never a real destination, so it never creates a hazard.
  always_comb begin
    hazard = id_valid && ex_q.mem_read && ex_q.reg_wr && (ex_q.rd != 5'd0) &&
             ((id_useRs && (id_rs == ex_q.rd)) || (id_useRt && (id_rt == ex_q.rd)));
  end

  // A taken branch makes the ID instruction wrong-path, so it overrides the stall.
  assign flush  = branchTaken;
  assign stall  = hazard && !branchTaken;
  assign bubble = stall || flush;

  // Once the bubble enters EX the load has moved to MEM, which is what
  // limits every load-use stall to a single cycle.
  always_comb begin
    ex_d = '0;
    if (id_valid && !bubble) begin
      ex_d.reg_wr   = id_regWr;
      ex_d.mem_read = id_memRead;
      ex_d.rd       = id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_ONE;
      end
      if (flush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_ONE;
      end
    end
  end

  assign IDEXmemRead = ex_q.mem_read;
  assign IDEXrd      = ex_q.rd;
  assign EXMEMregWr  = mem_q.reg_wr && (mem_q.rd != 5'd0);
  assign EXMEMrd     = mem_q.rd;
  assign MEMWBregWr  = wb_q.reg_wr && (wb_q.rd != 5'd0);
  assign MEMWBrd     = wb_q.rd;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-003 Port list (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous active-high reset.
- `id_valid` in 1: an instruction occupies the ID stage.
- `id_rs` in 5: ID source register 1.
- `id_rt` in 5: ID source register 2.
- `id_useRs` in 1: the ID instruction reads rs.
- `id_useRt` in 1: the ID instruction reads rt.
- `id_regWr` in 1: the ID instruction writes the register file.
- `id_memRead` in 1: the ID instruction is a load.
- `id_rd` in 5: ID destination register, already muxed from rt/rd.
- `branchTaken` in 1: the branch in EX resolved as taken this cycle.
- `stall` out 1: hold PC and IF/ID.
- `bubble` out 1: zero the control signals entering ID/EX.
- `flush` out 1: clear IF/ID.
- `EXMEMregWr` out 1 and `EXMEMrd` out 5: shadow of the instruction in MEM.
- `MEMWBregWr` out 1 and `MEMWBrd` out 5: shadow of the instruction in WB.
- `IDEXmemRead` out 1 and `IDEXrd` out 5: shadow of the instruction in EX.
- `stallCnt` out CNT_W: stall cycles since reset.
- `flushCnt` out CNT_W: flushes since reset.

Function
REQ-004 Shadow pipeline: three registered stage slots, EX, MEM and WB, each holding {regWr, memRead, rd}; they advance every clock edge with no enable.
REQ-005 Advance rule on each edge: WB <= MEM, MEM <= EX, EX <= ID fields, or <= bubble {0,0,5'b0} when `bubble` is 1.
REQ-006 ID fields with `id_valid` = 0 load EX as a bubble.
REQ-007 Load-use hazard (combinational) is 1 when all of the following hold:
- `id_valid`;
- EX.memRead and EX.regWr;
- EX.rd != 0;
- (`id_useRs` and `id_rs` == EX.rd) or (`id_useRt` and `id_rt` == EX.rd).
REQ-008 `flush` = `branchTaken`, combinational, same cycle.
REQ-009 `stall` = hazard AND NOT `branchTaken`; a taken branch suppresses the stall because the ID instruction is wrong-path.
REQ-010 `bubble` = `stall` OR `flush`.
REQ-011 Stall length: exactly one cycle per load-use pair. After the bubble enters EX, the load sits in MEM and the hazard deasserts.
REQ-012 The `stall` output shall never be high for two consecutive cycles caused by the same load.
REQ-013 Back-to-back loads, where load B depends on load A: one stall for A-to-B, then one stall for B-to-consumer if that consumer depends on B.
REQ-014 A destination register of 0 never triggers a stall and never counts as a writer for the outputs.
- `EXMEMregWr` and `MEMWBregWr` are forced to 0 when the corresponding rd is 0.
REQ-015 Shadow outputs are registered slot contents, with zero combinational path from inputs.
REQ-016 `stallCnt` increments by 1 on each edge where `stall` = 1 and saturates at all-ones.
REQ-017 `flushCnt` follows the same rule using `flush`.
REQ-018 All of `stall`, `bubble` and `flush` depend only on the current inputs and the EX slot, with no extra latency.

Reset
REQ-019 When `rst` asserts, asynchronously and immediately:
- all slots become {0,0,5'b0};
- both counters become 0;
- hence `stall` = 0 and all shadow outputs are 0.
REQ-020 Reset asserted mid-stall clears EX at once, so `stall` drops in the same cycle even if the ID inputs are held.
REQ-021 The first edge after `rst` deasserts loads EX from the ID inputs normally.

Verification
REQ-022 Load-use on rs: cycle 0 ID = lw rd=8, cycle 1 ID = add rs=8 -> `stall` = `bubble` = 1 in cycle 1 only.
- Cycle 2 shows `IDEXrd` = 0, `EXMEMrd` = 8, `EXMEMregWr` = 1, `stall` = 0.
- `stallCnt` = 1.
REQ-023 Load to $0: lw rd=0 followed by a use of rs=0 -> `stall` stays 0; `EXMEMregWr` = 0 one cycle later.
REQ-024 Branch over hazard: lw rd=9 in EX, ID reads rt=9 with `useRt` = 1, `branchTaken` = 1 in the same cycle.
- `stall` = 0, `flush` = 1, `bubble` = 1.
- `flushCnt` = 1, `stallCnt` = 0.
REQ-025 Shadow timing: ID = add rd=5 with `regWr` = 1 at cycle 0.
- `IDEXrd` = 5 at cycle 1, `EXMEMrd` = 5 at cycle 2, `MEMWBrd` = 5 at cycle 3, then 0 once bubbles follow.
REQ-026 Counter saturation: with CNT_W = 4, force 20 stall cycles -> `stallCnt` holds 15 and does not wrap.
REQ-027 Async reset mid-stall: pulse `rst` between edges while `stall` = 1.
- `stall`, all shadow outputs and both counters read 0 before the next clock edge.
